// File: rtl/ccff_loader.sv
// Byte-stream to serial loader for a configuration flip-flop chain, with gated-shift enable.
// Optional CCFF_LOADER_VERIFY_EN prepends marker 8'hA5 and checks it at ccff_tail.
module ccff_loader #(
   parameter int CHAIN_LEN = 64
) (
   input  logic       prog_clk,
   input  logic       pReset,
   input  logic       start,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       ccff_head,
   output logic       ccff_shift_en,
   input  logic       ccff_tail,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int NB        = (CHAIN_LEN + 7) / 8;
   localparam int LAST_BITS = CHAIN_LEN - 8 * (NB - 1);
   localparam int BW        = $clog2(NB + 1);
   localparam logic [BW-1:0] NB_C       = BW'(NB);
   localparam logic [7:0]    MARKER_PAT = 8'hA5;

   typedef enum logic [1:0] {S_IDLE, S_MARKER, S_LOAD, S_FIN} state_t;

   state_t          r_state, w_next;
   logic [7:0]      r_buf;
   logic [3:0]      r_bits_left;
   logic [BW-1:0]   r_bytes;
   logic [2:0]      r_mk_cnt;
   logic            r_head, r_shift_en;
   logic            w_hs, w_last_byte, w_data_done;

   // r_bits_left counts bits still waiting behind the one currently on r_head
   assign s_ready     = (r_state == S_LOAD) && (r_bytes != NB_C) && (r_bits_left == 4'd0);
   assign w_hs        = s_ready && s_valid;
   assign w_last_byte = (r_bytes == NB_C - BW'(1));
   assign w_data_done = (r_bytes == NB_C) && (r_bits_left == 4'd0);

   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_FIN);

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
`ifdef CCFF_LOADER_VERIFY_EN
               w_next = S_MARKER;
`else
               w_next = S_LOAD;
`endif
            end
         end
         S_MARKER: if (r_mk_cnt == 3'd7) w_next = S_LOAD;
         S_LOAD:   if (w_data_done) w_next = S_FIN;
         S_FIN:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         r_buf       <= '0;
         r_bits_left <= '0;
         r_bytes     <= '0;
         r_mk_cnt    <= '0;
         r_head      <= 1'b0;
         r_shift_en  <= 1'b0;
      end else begin
         r_shift_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_bytes     <= '0;
                  r_bits_left <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
                  r_shift_en  <= 1'b1;
                  r_head      <= MARKER_PAT[0];
                  r_mk_cnt    <= 3'd1;
`endif
               end
            end
            S_MARKER: begin
               r_shift_en <= 1'b1;
               r_head     <= MARKER_PAT[r_mk_cnt];
               r_mk_cnt   <= r_mk_cnt + 3'd1;
            end
            S_LOAD: begin
               // a new byte puts its bit 0 on the chain at the accepting edge
               if (w_hs) begin
                  r_shift_en  <= 1'b1;
                  r_head      <= s_data[0];
                  r_buf       <= {1'b0, s_data[7:1]};
                  r_bits_left <= w_last_byte ? 4'(LAST_BITS - 1) : 4'd7;
                  r_bytes     <= r_bytes + BW'(1);
               end else if (r_bits_left != 4'd0) begin
                  r_shift_en  <= 1'b1;
                  r_head      <= r_buf[0];
                  r_buf       <= {1'b0, r_buf[7:1]};
                  r_bits_left <= r_bits_left - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CCFF_LOADER_VERIFY_EN
   localparam int NW = $clog2(CHAIN_LEN + 9);

   logic [NW-1:0] r_nshift, w_noff;
   logic          r_err, w_in_win;

   // tail shows marker bit (n - CHAIN_LEN) once n shifts have completed
   assign w_noff   = r_nshift - NW'(CHAIN_LEN);
   assign w_in_win = (r_nshift >= NW'(CHAIN_LEN)) && (w_noff < NW'(8));

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         r_nshift <= '0;
         r_err    <= 1'b0;
      end else if ((r_state == S_IDLE) && start) begin
         r_nshift <= '0;
         r_err    <= 1'b0;
      end else if (r_shift_en) begin
         r_nshift <= r_nshift + NW'(1);
         if (w_in_win && (ccff_tail != MARKER_PAT[w_noff[2:0]])) r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   logic w_unused_tail;
   assign w_unused_tail = ccff_tail;
   assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Randomised bench for ccff_loader (CHAIN_LEN=20) against a behavioural chain model.
// Adapts its expectations to CCFF_LOADER_VERIFY_EN.
module tb_ccff_loader;

   localparam int CL = 20;
   localparam int NB = 3;
`ifdef CCFF_LOADER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int MK = VERIFY ? 8 : 0;
   localparam logic [7:0] MARKER = 8'hA5;

   logic       prog_clk, pReset, start, s_valid, s_ready;
   logic [7:0] s_data;
   logic       ccff_head, ccff_shift_en, ccff_tail, busy, done, err;

   ccff_loader #(.CHAIN_LEN(CL)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .err(err)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   int cyc = 0;
   always @(posedge prog_clk) cyc <= cyc + 1;

   // chain model: new bit enters at the top, chain[0] is the tail flop
   logic [CL-1:0] chain;
   logic          short_chain;
   always @(posedge prog_clk) if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
   assign ccff_tail = short_chain ? chain[1] : chain[0];

   int          m_nshift, m_nacc, m_ndone, m_first, m_last, m_done_cyc;
   logic [63:0] m_stream;
   always @(negedge prog_clk) begin
      if (ccff_shift_en) begin
         if (m_nshift == 0) m_first = cyc;
         m_last = cyc;
         if (m_nshift < 64) m_stream[m_nshift] = ccff_head;
         m_nshift++;
      end
      if (done) begin
         m_ndone++;
         m_done_cyc = cyc;
      end
      if (s_valid && s_ready) m_nacc++;
   end

   int         n_tests = 0, n_fail = 0;
   int         st_cyc;
   logic [7:0] src [0:NB];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CL-1:0] exp_chain();
      logic [CL-1:0] v;
      for (int i = 0; i < CL; i++) v[i] = src[i/8][i%8];
      return v;
   endfunction

   function automatic logic [63:0] exp_stream();
      logic [63:0] v;
      int k;
      v = '0;
      k = 0;
      if (VERIFY) for (int i = 0; i < 8; i++) begin v[k] = MARKER[i]; k++; end
      for (int i = 0; i < CL; i++) begin v[k] = src[i/8][i%8]; k++; end
      return v;
   endfunction

   task automatic clr_mon();
      m_nshift = 0; m_nacc = 0; m_ndone = 0; m_first = 0; m_last = 0; m_done_cyc = 0;
      m_stream = '0;
   endtask

   // stall_len: ready cycles refused after the first byte; abort_at: stop after that many shifts
   task automatic do_load(input int stall_len, input bit rnd, input bit poke, input int abort_at);
      int idx, stall, guard;
      bit hs;
      idx = 0; stall = 0; guard = 0;
      clr_mon();
      s_valid = 1'b0;
      start = 1'b1;
      @(posedge prog_clk); #1;
      st_cyc = cyc;
      start = 1'b0;
      chk("err_clr_on_start", err, 0);
      chk("busy_on_start", busy, 1);
      while (m_ndone == 0 && guard < 300) begin
         if (idx <= NB && !(idx >= 1 && stall > 0) && !(rnd && $urandom_range(0, 3) == 0)) begin
            s_valid = 1'b1;
            s_data  = src[idx];
         end else begin
            s_valid = 1'b0;
         end
         start = poke && (idx == 1);
         @(negedge prog_clk);
         hs = s_valid && s_ready;
         if (idx >= 1 && stall > 0 && s_ready) stall--;
         @(posedge prog_clk); #1;
         if (hs) begin
            idx++;
            if (idx == 1) stall = stall_len;
         end
         guard++;
         if (abort_at > 0 && m_nshift >= abort_at) break;
      end
      start   = 1'b0;
      s_valid = 1'b0;
      chk("load_within_budget", guard < 300, 1);
   endtask

   task automatic post_checks(input int exp_gaps, input bit chk_gaps, input bit exp_err);
      chk("shift_count", m_nshift, CL + MK);
      chk("bytes_accepted", m_nacc, NB);
      chk("done_pulses", m_ndone, 1);
      chk("done_after_last_shift", m_done_cyc, m_last + 1);
      chk("chain_contents", 64'(chain), 64'(exp_chain()));
      chk("head_stream", m_stream, exp_stream());
      chk("err_after_load", err, exp_err);
      chk("idle_after_load", busy, 0);
      if (chk_gaps) chk("shift_gaps", m_last - m_first + 1 - m_nshift, exp_gaps);
   endtask

   initial begin
      pReset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; short_chain = 1'b0;
      chain = '0;
      clr_mon();
      repeat (3) @(posedge prog_clk);
      @(negedge prog_clk);
      chk("reset_outputs", {s_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
      @(posedge prog_clk); #1 pReset = 1'b1;

      // valid offered in IDLE must not be taken
      s_valid = 1'b1; s_data = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge prog_clk);
         chk("idle_s_ready", s_ready, 0);
      end
      @(posedge prog_clk); #1 s_valid = 1'b0;
      chk("idle_no_accept", m_nacc, 0);
      chk("idle_no_shift", m_nshift, 0);

      src[0] = 8'h3C; src[1] = 8'hA1; src[2] = 8'hF7; src[3] = 8'h5E;
      do_load(0, 1'b0, 1'b0, 0);
      post_checks(0, 1'b1, 1'b0);
      chk("chain_7A13C", 64'(chain), 64'h7A13C);
      chk("done_latency_ok", (m_done_cyc - st_cyc) <= 22 + MK, 1);
      chk("first_shift_cycle", m_first - st_cyc, VERIFY ? 0 : 1);

      do_load(5, 1'b0, 1'b0, 0);
      post_checks(5, 1'b1, 1'b0);
      chk("stall_chain_7A13C", 64'(chain), 64'h7A13C);

      do_load(0, 1'b0, 1'b1, 0);
      post_checks(0, 1'b1, 1'b0);

      short_chain = 1'b1;
      do_load(0, 1'b0, 1'b0, 0);
      post_checks(0, 1'b1, VERIFY);
      repeat (4) @(posedge prog_clk);
      @(negedge prog_clk);
      chk("err_sticky", err, VERIFY);
      short_chain = 1'b0;
      @(posedge prog_clk); #1;
      src[0] = 8'h55; src[1] = 8'hAA; src[2] = 8'h0F; src[3] = 8'h33;
      do_load(0, 1'b0, 1'b0, 0);
      post_checks(0, 1'b1, 1'b0);

      // async reset part-way through a load
      src[0] = 8'hC3; src[1] = 8'h96; src[2] = 8'h7E; src[3] = 8'h01;
      do_load(0, 1'b0, 1'b0, 7);
      pReset = 1'b0;
      #1 chk("async_reset_outputs", {s_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
      repeat (2) @(posedge prog_clk);
      @(negedge prog_clk);
      chk("reset_held_outputs", {s_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
      @(posedge prog_clk); #1 pReset = 1'b1;
      do_load(0, 1'b0, 1'b0, 0);
      post_checks(0, 1'b1, 1'b0);

      for (int r = 0; r < 12; r++) begin
         for (int b = 0; b <= NB; b++) src[b] = 8'($urandom);
         do_load(0, 1'b1, 1'b0, 0);
         post_checks(0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader that drives the `ccff_head` end of a tile configuration chain and observes its `ccff_tail` end. It accepts the bitstream as a byte stream over a valid/ready handshake and serialises it one bit per shift. Each shift is qualified by an enable that an external clock-gate cell uses to gate `prog_clk` into the fabric, so input stalls never corrupt the chain. It sits between the bitstream source (host/SPI bridge) and the top-level chain head.

## Interface
- `CHAIN_LEN`, default 64, meaning: number of configuration flip-flops in the driven chain; minimum 1.
- `prog_clk`  in  1  programming clock; all logic is on the rising edge.
- `pReset`  in  1  asynchronous reset, active-low.
- `start`  in  1  begin a load; sampled only in IDLE.
- `s_data`  in  8  bitstream byte; bit 0 is shifted first.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `ccff_head`  out  1  serial data into the chain head.
- `ccff_shift_en`  out  1  high = chain shifts on this edge (gated-clock enable).
- `ccff_tail`  in  1  serial output of the last chain flip-flop.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  verify mismatch; sticky until the next accepted `start`.

## Operation
- States: IDLE, MARKER (only with verify), LOAD, FIN.
- Byte and bit accounting:
  - Bytes required: NB = ceil(CHAIN_LEN/8).
  - Bits used from the last byte: CHAIN_LEN - 8*(NB-1), taken LSB-first; the unused upper bits are discarded and never shifted.
- IDLE → MARKER (or LOAD) when `start`=1.
  - Clears `err` and the shift/byte counters.
  - `start` in any other state is ignored.
- MARKER: shifts the 8-bit marker 8'hA5 into the chain, bit 0 first, for 8 consecutive shift cycles, then moves to LOAD.
- LOAD:
  - A one-byte shift buffer plus a bit counter feed the chain.
  - `s_ready` is 1 when bytes remain to be accepted and either the buffer is empty or its last bit is being shifted in this cycle. This gives back-to-back bytes with no bubble.
  - A handshake (`s_valid` & `s_ready`) loads the buffer.
  - While the buffer holds a pending bit, the loader registers `ccff_shift_en`=1 and `ccff_head`=that bit. Otherwise `ccff_shift_en`=0 and `ccff_head` holds its last value.
  - After the final data bit is shifted, the state moves to FIN.
- FIN:
  - Pulses `done` for one cycle, then returns to IDLE.
  - Total shift cycles per load are exactly CHAIN_LEN (or CHAIN_LEN+8 with verify).
- `busy` = state ≠ IDLE.
- `s_ready` is 0 in IDLE, MARKER and FIN. Bytes offered beyond NB are never accepted.
- Async reset mid-load:
  - All state and outputs clear immediately.
  - Chain contents are undefined; a new `start` is required.

## Timing
- Reset values: `s_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `err`=0.
- `ccff_head` and `ccff_shift_en` are registered. A byte accepted at edge k produces its bit 0 with `ccff_shift_en`=1 in the cycle after edge k.
- Throughput: 1 bit/cycle while `s_valid` is held high. A deasserted `s_valid` inserts cycles with `ccff_shift_en`=0, and the chain holds.
- `start` at edge s:
  - The first shift cycle is s+1 (the marker, or the first data bit once a byte is accepted).
  - `done` pulses in the cycle after the last `ccff_shift_en`=1 cycle.
  - `busy` falls with `done`.
- `ccff_tail` is sampled combinationally against the completed-shift count n. The chain model is CHAIN_LEN flops advancing only on `ccff_shift_en`.

## Configuration
- `CCFF_LOADER_VERIFY_EN` defined:
  - MARKER state is present; 8'hA5 is prepended.
  - For n = CHAIN_LEN … CHAIN_LEN+7, `ccff_tail` is compared against marker bit n-CHAIN_LEN once per n. Any mismatch sets `err`.
  - After CHAIN_LEN+8 shifts, the chain holds exactly the data bits.
- Not defined:
  - No MARKER state; exactly CHAIN_LEN shifts per load.
  - `err` is tied to 0.

## Test plan
- CHAIN_LEN=20, verify off, bytes 8'h3C, 8'hA1, 8'hF7 with `s_valid` held → 20 consecutive `ccff_shift_en` cycles. Chain model holds 20'h7A13C (last byte nibble 4'hF discarded). `done` pulses at cycle start+22 or earlier. No 4th byte is accepted.
- Same load with `s_valid` dropped for 5 cycles after the first byte → exactly 5 `ccff_shift_en`=0 gaps and an identical final chain contents.
- Verify on, CHAIN_LEN=16, correct chain model, data 8'h55, 8'hAA → 24 shifts, chain = 16'hAA55, `err`=0, `done`=1 once.
- Verify on, chain model shortened to 15 flops → `err`=1 after the load and stays 1 until the next `start`.
- `pReset` asserted low after the 7th shift → every output is 0 within the same cycle. A following `start` reloads correctly from shift 0.
- `start` pulsed while `busy`=1, and `s_valid`=1 in IDLE → no effect; `s_ready` stays 0 in IDLE.
